// File: rtl/stack_alu_pkg.sv
// Shared opcode/state encodings and the signed add/sub overflow rule for the stack ALU.
// Pure definitions: no latency, no flow control.
package stack_alu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_PUSH  = 4'd1,
      OP_POP   = 4'd2,
      OP_PEEK  = 4'd3,
      OP_ADD   = 4'd4,
      OP_SUB   = 4'd5,
      OP_MUL   = 4'd6,
      OP_DUP   = 4'd7,
      OP_SWAP  = 4'd8,
      OP_CLEAR = 4'd9
   } op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_e;

   // Sign bits only: add overflows on like-signed operands, sub on unlike-signed ones.
   function automatic logic addsub_ovf(input logic i_sub, input logic i_s_sgn,
                                       input logic i_t_sgn, input logic i_r_sgn);
      return (((i_s_sgn ^ i_t_sgn) == i_sub) && (i_r_sgn != i_s_sgn));
   endfunction

endpackage

// File: rtl/seq_signed_mul.sv
// Signed shift-add multiplier, one partial product per cycle; o_done/o_product are combinational on the
// DATA_WIDTH-th cycle after i_start. No backpressure: the caller must not restart while a product is in flight.
module seq_signed_mul #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [DATA_WIDTH-1:0]   i_a,
   input  logic [DATA_WIDTH-1:0]   i_b,
   output logic                    o_done,
   output logic [2*DATA_WIDTH-1:0] o_product
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic                    r_busy;
   logic [CW-1:0]           r_cnt;
   logic [2*DATA_WIDTH-1:0] r_acc;
   logic [2*DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0]   r_mplier;

   logic                    w_last;
   logic [2*DATA_WIDTH-1:0] w_pp;
   logic [2*DATA_WIDTH-1:0] w_acc_nxt;

   // The multiplier MSB carries negative weight, so its partial product is subtracted.
   assign w_last    = r_busy && (r_cnt == CW'(DATA_WIDTH - 1));
   assign w_pp      = r_mplier[0] ? r_mcand : '0;
   assign w_acc_nxt = w_last ? (r_acc - w_pp) : (r_acc + w_pp);
   assign o_done    = w_last;
   assign o_product = w_acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/param_stack_alu.sv
// Signed LIFO operand stack with ALU on the top two entries; all effects registered, 1 cycle after accept.
// cmd_ready drops for DATA_WIDTH cycles during MUL; the result pulses out as cmd_ready returns.
module param_stack_alu
   import stack_alu_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int STACK_SIZE = 64,
   localparam int PTR_W      = $clog2(STACK_SIZE + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [PTR_W-1:0]      depth,
   output logic                  err_underflow,
   output logic                  err_full,
   output logic                  arith_ovf,
   output logic                  err_sticky
);

   localparam int AW = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;

   state_e                  r_state, w_state_nxt;
   logic [PTR_W-1:0]        r_depth, w_depth_nxt;
   logic [DATA_WIDTH-1:0]   r_mem [STACK_SIZE];
   logic                    r_out_vld, w_out_vld;
   logic [DATA_WIDTH-1:0]   r_out_dat, w_out_dat;
   logic                    r_err_uf, w_err_uf;
   logic                    r_err_full, w_err_full;
   logic                    r_ovf, w_ovf;
   logic                    r_sticky, w_clear;

   logic                    w_we0, w_we1;
   logic [AW-1:0]           w_wa0, w_wa1;
   logic [DATA_WIDTH-1:0]   w_wd0, w_wd1;
   logic [AW-1:0]           w_ia_p, w_ia_t, w_ia_s;
   logic [DATA_WIDTH-1:0]   w_t, w_s, w_sum, w_diff;
   logic                    w_accept, w_mul_start, w_mul_done;
   logic [2*DATA_WIDTH-1:0] w_mul_prod;

   assign w_ia_p   = AW'(r_depth);
   assign w_ia_t   = AW'(r_depth - PTR_W'(1));
   assign w_ia_s   = AW'(r_depth - PTR_W'(2));
   assign w_t      = r_mem[w_ia_t];
   assign w_s      = r_mem[w_ia_s];
   assign w_sum    = w_s + w_t;
   assign w_diff   = w_s - w_t;
   assign w_accept = cmd_valid && (r_state == ST_IDLE);

   seq_signed_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_mul_start),
      .i_a       (w_s),
      .i_b       (w_t),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_depth_nxt = r_depth;
      w_out_vld   = 1'b0;
      w_out_dat   = '0;
      w_err_uf    = 1'b0;
      w_err_full  = 1'b0;
      w_ovf       = 1'b0;
      w_clear     = 1'b0;
      w_mul_start = 1'b0;
      w_we0       = 1'b0;
      w_wa0       = w_ia_s;
      w_wd0       = '0;
      w_we1       = 1'b0;
      w_wa1       = w_ia_t;
      w_wd1       = '0;
      case (r_state)
         ST_IDLE: if (w_accept) begin
            case (cmd_op)
               OP_PUSH, OP_DUP: begin
                  if (cmd_op == OP_DUP && r_depth == '0) w_err_uf = 1'b1;
                  else if (r_depth == PTR_W'(STACK_SIZE)) w_err_full = 1'b1;
                  else begin
                     w_we0       = 1'b1;
                     w_wa0       = w_ia_p;
                     w_wd0       = (cmd_op == OP_DUP) ? w_t : cmd_data;
                     w_depth_nxt = r_depth + PTR_W'(1);
                  end
               end
               OP_POP, OP_PEEK: begin
                  if (r_depth == '0) w_err_uf = 1'b1;
                  else begin
                     w_out_vld = 1'b1;
                     w_out_dat = w_t;
                     if (cmd_op == OP_POP) w_depth_nxt = r_depth - PTR_W'(1);
                  end
               end
               OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                  if (r_depth < PTR_W'(2)) w_err_uf = 1'b1;
                  else if (cmd_op == OP_MUL) begin
                     w_mul_start = 1'b1;
                     w_state_nxt = ST_MUL_BUSY;
                  end else if (cmd_op == OP_SWAP) begin
                     w_we0 = 1'b1;
                     w_wd0 = w_t;
                     w_we1 = 1'b1;
                     w_wd1 = w_s;
                  end else begin
                     w_we0       = 1'b1;
                     w_wd0       = (cmd_op == OP_SUB) ? w_diff : w_sum;
                     w_out_vld   = 1'b1;
                     w_out_dat   = w_wd0;
                     w_ovf       = addsub_ovf(cmd_op == OP_SUB, w_s[DATA_WIDTH-1],
                                              w_t[DATA_WIDTH-1], w_wd0[DATA_WIDTH-1]);
                     w_depth_nxt = r_depth - PTR_W'(1);
                  end
               end
               OP_CLEAR: begin
                  w_depth_nxt = '0;
                  w_clear     = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MUL_BUSY: if (w_mul_done) begin
            w_we0       = 1'b1;
            w_wd0       = w_mul_prod[DATA_WIDTH-1:0];
            w_out_vld   = 1'b1;
            w_out_dat   = w_mul_prod[DATA_WIDTH-1:0];
            w_ovf       = (w_mul_prod[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{w_mul_prod[DATA_WIDTH-1]}});
            w_depth_nxt = r_depth - PTR_W'(1);
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_depth    <= '0;
         r_out_vld  <= 1'b0;
         r_out_dat  <= '0;
         r_err_uf   <= 1'b0;
         r_err_full <= 1'b0;
         r_ovf      <= 1'b0;
         r_sticky   <= 1'b0;
      end else begin
         r_depth    <= w_depth_nxt;
         r_out_vld  <= w_out_vld;
         r_out_dat  <= w_out_dat;
         r_err_uf   <= w_err_uf;
         r_err_full <= w_err_full;
         r_ovf      <= w_ovf;
         r_sticky   <= w_clear ? 1'b0 : (r_sticky | r_err_uf | r_err_full | r_ovf);
      end
   end

   // Stack storage carries no reset; only the depth pointer defines valid contents.
   always_ff @(posedge clk) begin
      if (w_we0) r_mem[w_wa0] <= w_wd0;
      if (w_we1) r_mem[w_wa1] <= w_wd1;
   end

   assign cmd_ready     = (r_state == ST_IDLE);
   assign out_valid     = r_out_vld;
   assign out_data      = r_out_dat;
   assign depth         = r_depth;
   assign err_underflow = r_err_uf;
   assign err_full      = r_err_full;
   assign arith_ovf     = r_ovf;
   assign err_sticky    = r_sticky;

endmodule

// File: tb/tb_param_stack_alu.sv
// Bench for param_stack_alu (DATA_WIDTH=8, STACK_SIZE=4): table of single-cycle ops plus MUL/reset sequences.
// Results are matched against a queue of expected {data, ovf} filled as commands are driven.
module tb_param_stack_alu;
   import stack_alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] depth;
   logic       err_underflow, err_full, arith_ovf, err_sticky;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   typedef struct {
      logic [3:0] op;
      logic [7:0] dat;
      logic       uf;
      logic       full;
      logic [2:0] dep;
      logic       vld;
      logic [7:0] res;
      logic       ovf;
   } vec_t;
   vec_t tbl[$];

   param_stack_alu #(.DATA_WIDTH(8), .STACK_SIZE(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_data      (cmd_data),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .depth         (depth),
      .err_underflow (err_underflow),
      .err_full      (err_full),
      .arith_ovf     (arith_ovf),
      .err_sticky    (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("out_data", {24'd0, out_data}, {24'd0, e[8:1]});
            chk("arith_ovf", {31'd0, arith_ovf}, {31'd0, e[0]});
         end
      end
   end

   task automatic row(input logic [3:0] op, input logic [7:0] dat, input logic uf, input logic full,
                      input logic [2:0] dep, input logic vld, input logic [7:0] res, input logic ovf);
      vec_t v;
      v = '{op, dat, uf, full, dep, vld, res, ovf};
      tbl.push_back(v);
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] dat);
      cmd_op = op;
      cmd_data = dat;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 4'd0;
      cmd_data = 8'd0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      logic m_st, m_pend, exp_st;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic m_st, m_pend, exp_st;
      m_st = 1'b0;
      m_pend = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_depth", {29'd0, depth}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //   op        dat    uf full dep vld res    ovf
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);
      row(OP_PUSH,  8'd5,   0, 0,  1,  0, 8'h00, 0);
      row(OP_PUSH,  8'd3,   0, 0,  2,  0, 8'h00, 0);
      row(OP_ADD,   8'd0,   0, 0,  1,  1, 8'h08, 0);
      row(OP_SUB,   8'd0,   1, 0,  1,  0, 8'h00, 0);
      row(OP_POP,   8'd0,   0, 0,  0,  1, 8'h08, 0);
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);
      row(OP_PUSH,  8'd100, 0, 0,  1,  0, 8'h00, 0);
      row(OP_PUSH,  8'd50,  0, 0,  2,  0, 8'h00, 0);
      row(OP_ADD,   8'd0,   0, 0,  1,  1, 8'h96, 1);
      row(OP_PUSH,  8'd10,  0, 0,  2,  0, 8'h00, 0);
      row(OP_PUSH,  8'd3,   0, 0,  3,  0, 8'h00, 0);
      row(OP_SUB,   8'd0,   0, 0,  2,  1, 8'h07, 0);
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);
      row(OP_PUSH,  8'd1,   0, 0,  1,  0, 8'h00, 0);
      row(OP_PUSH,  8'd2,   0, 0,  2,  0, 8'h00, 0);
      row(OP_PUSH,  8'd3,   0, 0,  3,  0, 8'h00, 0);
      row(OP_PUSH,  8'd4,   0, 0,  4,  0, 8'h00, 0);
      row(OP_PUSH,  8'd9,   0, 1,  4,  0, 8'h00, 0);
      row(OP_DUP,   8'd0,   0, 1,  4,  0, 8'h00, 0);
      row(OP_POP,   8'd0,   0, 0,  3,  1, 8'h04, 0);
      row(OP_POP,   8'd0,   0, 0,  2,  1, 8'h03, 0);
      row(OP_POP,   8'd0,   0, 0,  1,  1, 8'h02, 0);
      row(OP_POP,   8'd0,   0, 0,  0,  1, 8'h01, 0);
      row(OP_POP,   8'd0,   1, 0,  0,  0, 8'h00, 0);
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);
      row(OP_PUSH,  8'h80,  0, 0,  1,  0, 8'h00, 0);
      row(OP_PUSH,  8'd1,   0, 0,  2,  0, 8'h00, 0);
      row(OP_SUB,   8'd0,   0, 0,  1,  1, 8'h7F, 1);
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);
      row(OP_PUSH,  8'd1,   0, 0,  1,  0, 8'h00, 0);
      row(OP_PUSH,  8'd2,   0, 0,  2,  0, 8'h00, 0);
      row(OP_SWAP,  8'd0,   0, 0,  2,  0, 8'h00, 0);
      row(OP_PEEK,  8'd0,   0, 0,  2,  1, 8'h01, 0);
      row(OP_DUP,   8'd0,   0, 0,  3,  0, 8'h00, 0);
      row(OP_POP,   8'd0,   0, 0,  2,  1, 8'h01, 0);
      row(OP_POP,   8'd0,   0, 0,  1,  1, 8'h01, 0);
      row(OP_POP,   8'd0,   0, 0,  0,  1, 8'h02, 0);
      row(4'd12,    8'd77,  0, 0,  0,  0, 8'h00, 0);
      row(OP_PEEK,  8'd0,   1, 0,  0,  0, 8'h00, 0);
      row(OP_CLEAR, 8'd0,   0, 0,  0,  0, 8'h00, 0);

      foreach (tbl[i]) begin
         if (tbl[i].vld) exp_q.push_back({tbl[i].res, tbl[i].ovf});
         issue(tbl[i].op, tbl[i].dat);
         chk($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
         if (!tbl[i].vld) chk($sformatf("row%0d_out_data_idle", i), {24'd0, out_data}, 32'd0);
         chk($sformatf("row%0d_underflow", i), {31'd0, err_underflow}, {31'd0, tbl[i].uf});
         chk($sformatf("row%0d_full", i), {31'd0, err_full}, {31'd0, tbl[i].full});
         chk($sformatf("row%0d_depth", i), {29'd0, depth}, {29'd0, tbl[i].dep});
         exp_st = (tbl[i].op == OP_CLEAR) ? 1'b0 : (m_st | m_pend);
         chk($sformatf("row%0d_sticky", i), {31'd0, err_sticky}, {31'd0, exp_st});
         m_st = exp_st;
         m_pend = tbl[i].uf | tbl[i].full | (tbl[i].vld & tbl[i].ovf);
      end

      // -4 * 7 = -28, fits in 8 bits
      issue(OP_PUSH, 8'hFC);
      issue(OP_PUSH, 8'd7);
      exp_q.push_back({8'hE4, 1'b0});
      issue(OP_MUL, 8'd0);
      wait_ready(n);
      chk("mul1_busy_cycles", n, 32'd8);
      chk("mul1_depth", {29'd0, depth}, 32'd1);

      // 16 * 16 = 256 overflows
      issue(OP_PUSH, 8'd16);
      issue(OP_PUSH, 8'd16);
      exp_q.push_back({8'h00, 1'b1});
      issue(OP_MUL, 8'd0);
      wait_ready(n);
      chk("mul2_busy_cycles", n, 32'd8);
      chk("mul2_depth", {29'd0, depth}, 32'd2);

      // PUSH held valid through MUL_BUSY must be taken exactly once, after ready returns
      exp_q.push_back({8'h00, 1'b0});
      cmd_op = OP_MUL;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_op = OP_PUSH;
      cmd_data = 8'h55;
      chk("held_ready_low", {31'd0, cmd_ready}, 32'd0);
      wait_ready(n);
      chk("held_busy_cycles", n, 32'd8);
      chk("held_depth_before", {29'd0, depth}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 4'd0;
      cmd_data = 8'd0;
      chk("held_depth_after", {29'd0, depth}, 32'd2);
      exp_q.push_back({8'h55, 1'b0});
      issue(OP_PEEK, 8'd0);
      @(posedge clk);
      #1;
      chk("pre_reset_sticky", {31'd0, err_sticky}, 32'd1);

      // Reset in the middle of a multiply
      issue(OP_PUSH, 8'd3);
      issue(OP_MUL, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midmul_rst_depth", {29'd0, depth}, 32'd0);
      chk("midmul_rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("midmul_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midmul_rst_out_data", {24'd0, out_data}, 32'd0);
      chk("midmul_rst_flags", {28'd0, err_underflow, err_full, arith_ovf, err_sticky}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_depth", {29'd0, depth}, 32'd0);
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

      // MUL with a single operand underflows and never leaves IDLE
      issue(OP_PUSH, 8'd2);
      issue(OP_MUL, 8'd0);
      chk("mul_uf_flag", {31'd0, err_underflow}, 32'd1);
      chk("mul_uf_ready", {31'd0, cmd_ready}, 32'd1);
      chk("mul_uf_depth", {29'd0, depth}, 32'd1);
      repeat (12) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
